// File: rtl/move_stream_if.sv
// move_stream_if: valid/ready stream carrying one generated position per transfer.
// Ports (master drives, slave receives):
//   out_valid, out_board, out_white_to_move, out_castle_mask, out_en_passant_col, out_index, out_last
//   out_ready (driven by the slave)
interface move_stream_if #(
    parameter int BOARD_WIDTH = 256,
    parameter int INDEX_WIDTH = 6
);
    logic                   out_valid;
    logic                   out_ready;
    logic [BOARD_WIDTH-1:0] out_board;
    logic                   out_white_to_move;
    logic [3:0]             out_castle_mask;
    logic [3:0]             out_en_passant_col;
    logic [INDEX_WIDTH-1:0] out_index;
    logic                   out_last;
    modport master (
        output out_valid, out_board, out_white_to_move, out_castle_mask, out_en_passant_col, out_index, out_last,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_board, out_white_to_move, out_castle_mask, out_en_passant_col, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/move_stream.sv
// move_stream: walks the all_moves list and streams each position on a valid/ready interface.
module move_stream #(
    parameter int PIECE_WIDTH = 4,
    parameter int BOARD_WIDTH = PIECE_WIDTH * 64,
    parameter int MAX_POSITIONS = 64,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
    parameter int RAM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
    input  logic [BOARD_WIDTH-1:0]        board_in,
    input  logic                          white_to_move_in,
    input  logic [3:0]                    castle_mask_in,
    input  logic [3:0]                    en_passant_col_in,
    output logic [MAX_POSITIONS_LOG2-1:0] move_index,
    output logic                          clear_moves,
    output logic                          busy,
    output logic                          done,
    move_stream_if.master                 stream
);
    localparam int W = MAX_POSITIONS_LOG2;
    localparam logic [1:0] LAT_INIT = 2'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WAIT_READY, FETCH, PRESENT, FINISH, CLEAR_WAIT} state_t;

    state_t       state, state_next;
    logic [W-1:0] cnt;
    logic [1:0]   lat;

    always_comb begin
        state_next  = state;
        busy        = state inside {WAIT_READY, FETCH, PRESENT, FINISH};
        done        = state == FINISH;
`ifdef MOVE_STREAM_AUTO_CLEAR_EN
        clear_moves = state == FINISH;
`else
        clear_moves = 1'b0;
`endif
        case (state)
            IDLE:       state_next = start ? WAIT_READY : IDLE;
            WAIT_READY: state_next = !moves_ready ? WAIT_READY : (move_count == '0) ? FINISH : FETCH;
            FETCH:      state_next = (lat == '0) ? PRESENT : FETCH;
            PRESENT:    state_next = !stream.out_ready ? PRESENT : stream.out_last ? FINISH : FETCH;
`ifdef MOVE_STREAM_AUTO_CLEAR_EN
            FINISH:     state_next = CLEAR_WAIT;
            CLEAR_WAIT: state_next = IDLE;
`else
            FINISH:     state_next = IDLE;
`endif
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                     <= IDLE;
            cnt                       <= '0;
            lat                       <= '0;
            move_index                <= '0;
            stream.out_valid          <= 1'b0;
            stream.out_board          <= '0;
            stream.out_white_to_move  <= 1'b0;
            stream.out_castle_mask    <= '0;
            stream.out_en_passant_col <= '0;
            stream.out_index          <= '0;
            stream.out_last           <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                WAIT_READY: begin
                    if (moves_ready) begin
                        cnt        <= move_count;
                        move_index <= '0;
                        lat        <= LAT_INIT;
                    end
                end
                FETCH: begin
                    if (lat == '0) begin
                        stream.out_valid          <= 1'b1;
                        stream.out_board          <= board_in;
                        stream.out_white_to_move  <= white_to_move_in;
                        stream.out_castle_mask    <= castle_mask_in;
                        stream.out_en_passant_col <= en_passant_col_in;
                        stream.out_index          <= move_index;
                        stream.out_last           <= move_index == cnt - W'(1);
                    end else begin
                        lat <= lat - 2'd1;
                    end
                end
                PRESENT: begin
                    if (stream.out_ready) begin
                        stream.out_valid <= 1'b0;
                        if (!stream.out_last) begin
                            move_index <= move_index + W'(1);
                            lat        <= LAT_INIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_move_stream.sv
// tb_move_stream: directed checks of move_stream at RAM latency 1 and 3 against a delayed-read move RAM model.
`timescale 1ns/1ps
module tb_move_stream;
    localparam int PW = 4;
    localparam int BW = PW * 64;
    localparam int MP = 64;
    localparam int LW = 6;
`ifdef MOVE_STREAM_AUTO_CLEAR_EN
    localparam bit AC = 1'b1;
`else
    localparam bit AC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          moves_ready = 1'b0;
    logic [LW-1:0] move_count = '0;
    logic          rdy_lvl = 1'b1;
    logic          pattern_mode = 1'b0;
    logic [4:0]    pattern = 5'b00101;
    logic          rdy;
    logic          clr = 1'b0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) pattern <= {pattern[0], pattern[4:1]};
    assign rdy = pattern_mode ? pattern[0] : rdy_lvl;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] ram_board(input logic [LW-1:0] i);
        ram_board = {8{32'(i) * 32'h9E3779B1}} ^ {32{8'hA5}};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = (g == 0) ? 1 : 3;
        move_stream_if #(.BOARD_WIDTH(BW), .INDEX_WIDTH(LW)) s ();
        logic [LW-1:0] move_index;
        logic [LW-1:0] hist [3];
        logic [LW-1:0] cur;
        logic          clear_moves, busy, done;
        always @(posedge clk) begin
            hist[0] <= move_index;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
        assign cur = (L == 1) ? move_index : hist[(L > 1) ? L - 2 : 0];
        assign s.out_ready = rdy;

        move_stream #(.PIECE_WIDTH(PW), .MAX_POSITIONS(MP), .RAM_LATENCY(L)) dut (
            .clk(clk), .reset(reset), .start(start), .moves_ready(moves_ready), .move_count(move_count),
            .board_in(ram_board(cur)), .white_to_move_in(cur[0]), .castle_mask_in(cur[3:0]),
            .en_passant_col_in(~cur[3:0]), .move_index(move_index), .clear_moves(clear_moves),
            .busy(busy), .done(done), .stream(s.master)
        );

        int            xfers, dones, clears, lasts, stalls, valid_cyc, busy_cyc, busy_first, done_cyc;
        int            gap_min, gap_max, last_cyc;
        logic          stalled = 1'b0;
        logic [BW-1:0] hb;
        logic [LW-1:0] hi;
        always @(negedge clk) begin
            if (clr || reset) begin
                stalled = 1'b0;
                if (clr) begin
                    xfers = 0; dones = 0; clears = 0; lasts = 0; stalls = 0; valid_cyc = 0; busy_cyc = 0;
                    busy_first = -1; done_cyc = -1; gap_min = 1000; gap_max = 0; last_cyc = 0;
                end
            end else begin
                if (stalled) begin
                    check("stall_valid", s.out_valid, 1);
                    check("stall_board", s.out_board, hb);
                    check("stall_index", s.out_index, hi);
                end
                stalled = s.out_valid && !s.out_ready;
                hb = s.out_board;
                hi = s.out_index;
                if (stalled) stalls++;
                if (s.out_valid) valid_cyc++;
                if (busy) begin
                    busy_cyc++;
                    if (busy_first < 0) busy_first = cyc;
                end
                if (done || clear_moves) check("clear_with_done", clear_moves, AC ? done : 1'b0);
                if (done) begin
                    dones++;
                    done_cyc = cyc;
                end
                if (clear_moves) clears++;
                if (s.out_valid && s.out_ready) begin
                    check("xfer_index", s.out_index, LW'(xfers));
                    check("xfer_board", s.out_board, ram_board(s.out_index));
                    check("xfer_meta", {s.out_white_to_move, s.out_castle_mask, s.out_en_passant_col},
                          {s.out_index[0], s.out_index[3:0], ~s.out_index[3:0]});
                    check("xfer_last", s.out_last, xfers == int'(move_count) - 1);
                    if (s.out_last) lasts++;
                    if (xfers > 0) begin
                        if (cyc - last_cyc < gap_min) gap_min = cyc - last_cyc;
                        if (cyc - last_cyc > gap_max) gap_max = cyc - last_cyc;
                    end
                    last_cyc = cyc;
                    xfers++;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((u[0].busy || u[1].busy) && n < 400) begin
            step();
            n++;
        end
        check(tag, n < 400, 1);
        step(3);
    endtask

    task automatic walk_checks(input int n);
        check("xfers_l1", u[0].xfers, n);
        check("xfers_l3", u[1].xfers, n);
        check("dones_l1", u[0].dones, 1);
        check("dones_l3", u[1].dones, 1);
        check("lasts_l1", u[0].lasts, (n > 0) ? 1 : 0);
        check("lasts_l3", u[1].lasts, (n > 0) ? 1 : 0);
        check("clears_l1", u[0].clears, AC);
        check("clears_l3", u[1].clears, AC);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        step(3);
        check("rst_valid", u[0].s.out_valid, 0);
        check("rst_busy", u[0].busy, 0);
        check("rst_done", u[0].done, 0);
        check("rst_clear", u[0].clear_moves, 0);
        check("rst_index", u[0].move_index, 0);
        check("rst_out", {u[0].s.out_board, u[0].s.out_index, u[0].s.out_last}, 0);
        reset = 1'b0;
        step();

        move_count = 6'd20;
        moves_ready = 1'b1;
        clear_stats();
        pulse_start();
        wait_idle("walk_timeout");
        walk_checks(20);
        check("gap_min_l1", u[0].gap_min, 2);
        check("gap_max_l1", u[0].gap_max, 2);
        check("gap_min_l3", u[1].gap_min, 4);
        check("gap_max_l3", u[1].gap_max, 4);

        pattern_mode = 1'b1;
        clear_stats();
        pulse_start();
        wait_idle("bp_timeout");
        walk_checks(20);
        check("bp_stalled_l1", u[0].stalls > 0, 1);
        check("bp_stalled_l3", u[1].stalls > 0, 1);
        pattern_mode = 1'b0;

        move_count = 6'd0;
        clear_stats();
        pulse_start();
        wait_idle("empty_timeout");
        walk_checks(0);
        check("empty_valid", u[0].valid_cyc, 0);
        check("empty_busy_cycles", u[0].busy_cyc, 2);
        check("empty_done_delay", u[0].done_cyc - u[0].busy_first, 1);
        check("empty_busy_cycles_l3", u[1].busy_cyc, 2);

        move_count = 6'd20;
        moves_ready = 1'b0;
        clear_stats();
        pulse_start();
        step(10);
        check("hold_busy", u[0].busy, 1);
        check("hold_valid", u[0].valid_cyc, 0);
        moves_ready = 1'b1;
        step(3);
        pulse_start();
        wait_idle("late_timeout");
        step(5);
        walk_checks(20);
        check("second_start_ignored", u[0].busy, 0);

        clear_stats();
        pulse_start();
        begin
            int n = 0;
            while (u[0].xfers < 7 && n < 400) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("reach_7th", u[0].xfers, 7);
        reset = 1'b1;
        step();
        check("mid_rst_valid", u[0].s.out_valid, 0);
        check("mid_rst_busy", u[0].busy, 0);
        check("mid_rst_done", u[0].done, 0);
        check("mid_rst_busy_l3", u[1].busy, 0);
        step();
        reset = 1'b0;
        step(2);
        check("mid_rst_dones", u[0].dones + u[1].dones, 0);
        check("mid_rst_clears", u[0].clears + u[1].clears, 0);
        clear_stats();
        pulse_start();
        wait_idle("fresh_timeout");
        walk_checks(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
